// File: rtl/rom_pkg.sv
// Shared ROM geometry and arbiter state encoding.
package rom_pkg;

   localparam int ROM_AW = 7;
   localparam int ROM_DW = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side
// that was not served last. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   // One-hot winner selection
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the single ROM read port between the ECC engine (requester 0) and
// the protocol unit (requester 1). A granted burst is broken into single-word
// reads; each returned word is forwarded to the owner of the grant.
// Every output is a register; the comb block computes their next values.
module rom_access_arbiter
   import rom_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          i_req,
   input  logic [ROM_AW-1:0]   i_addr0,
   input  logic [CNT_W-1:0]    i_wordcnt0,
   input  logic [ROM_AW-1:0]   i_addr1,
   input  logic [CNT_W-1:0]    i_wordcnt1,
   output logic [1:0]          o_gnt,
   output logic [1:0]          o_rvalid,
   output logic [ROM_DW-1:0]   o_rdata,
   output logic [1:0]          o_done,
   output logic                o_err,
   output logic                o_rd_rom,
   output logic [ROM_AW-1:0]   o_addr_rom,
   output logic [CNT_W-1:0]    o_wordcnt_rom,
   input  logic [ROM_DW-1:0]   i_data_rom_16bits,
   input  logic                i_fifo_full_rom
);

   arb_state_t          state_q, state_d;
   logic [ROM_AW-1:0]   cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic [TO_W-1:0]     wd_q, wd_d;
   logic                gidx_q, gidx_d;
   logic                last_grant_q, last_grant_d;
   logic                aborted_q, aborted_d;

   logic [1:0]          gnt_d, rvalid_d, done_d;
   logic [ROM_DW-1:0]   rdata_d;
   logic                err_d, rd_d;
   logic [ROM_AW-1:0]   addr_rom_d;
   logic [CNT_W-1:0]    wordcnt_rom_d;

   logic [1:0]          win;
   logic [ROM_AW-1:0]   win_addr;
   logic [CNT_W-1:0]    win_cnt;
   logic [ROM_AW-1:0]   next_addr;

   rr_arb2 u_arb (
      .req        (i_req),
      .last_grant (last_grant_q),
      .gnt        (win)
   );

   assign win_addr  = win[1] ? i_addr1    : i_addr0;
   assign win_cnt   = win[1] ? i_wordcnt1 : i_wordcnt0;
   // 7-bit address wraps naturally from 127 to 0
   assign next_addr = cur_addr_q + 1'b1;

   // Next-state and next-output computation
   always_comb begin
      state_d       = state_q;
      cur_addr_d    = cur_addr_q;
      rem_d         = rem_q;
      wd_d          = wd_q;
      gidx_d        = gidx_q;
      last_grant_d  = last_grant_q;
      aborted_d     = aborted_q;
      gnt_d         = o_gnt;
      rvalid_d      = 2'b00;
      done_d        = 2'b00;
      err_d         = 1'b0;
      rdata_d       = o_rdata;
      rd_d          = o_rd_rom;
      addr_rom_d    = o_addr_rom;
      wordcnt_rom_d = o_wordcnt_rom;

      case (state_q)
         ST_IDLE: begin
            if (win != 2'b00) begin
               gidx_d     = win[1];
               gnt_d      = win;
               cur_addr_d = win_addr;
               rem_d      = win_cnt;
               aborted_d  = 1'b0;
               if (win_cnt == '0) begin
                  // Empty burst: report completion without touching the ROM
                  state_d = ST_DONE;
               end else begin
                  state_d       = ST_ISSUE;
                  rd_d          = 1'b1;
                  addr_rom_d    = win_addr;
                  wordcnt_rom_d = win_cnt;
               end
            end
         end

         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (i_fifo_full_rom) begin
               rdata_d    = i_data_rom_16bits;
               rvalid_d   = o_gnt;
               cur_addr_d = next_addr;
               rem_d      = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  state_d       = ST_DONE;
                  rd_d          = 1'b0;
                  wordcnt_rom_d = '0;
               end else begin
                  // New address each word so the ROM side starts a fresh round
                  state_d       = ST_ISSUE;
                  rd_d          = 1'b1;
                  addr_rom_d    = next_addr;
                  wordcnt_rom_d = rem_q - 1'b1;
               end
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
               aborted_d     = 1'b1;
               state_d       = ST_DONE;
               rd_d          = 1'b0;
               wordcnt_rom_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         ST_DONE: begin
            done_d       = o_gnt;
            err_d        = aborted_q;
            last_grant_d = gidx_q;
            gnt_d        = 2'b00;
            state_d      = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cur_addr_q    <= '0;
         rem_q         <= '0;
         wd_q          <= '0;
         gidx_q        <= 1'b0;
         last_grant_q  <= 1'b1;
         aborted_q     <= 1'b0;
         o_gnt         <= 2'b00;
         o_rvalid      <= 2'b00;
         o_rdata       <= '0;
         o_done        <= 2'b00;
         o_err         <= 1'b0;
         o_rd_rom      <= 1'b0;
         o_addr_rom    <= '0;
         o_wordcnt_rom <= '0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         rem_q         <= rem_d;
         wd_q          <= wd_d;
         gidx_q        <= gidx_d;
         last_grant_q  <= last_grant_d;
         aborted_q     <= aborted_d;
         o_gnt         <= gnt_d;
         o_rvalid      <= rvalid_d;
         o_rdata       <= rdata_d;
         o_done        <= done_d;
         o_err         <= err_d;
         o_rd_rom      <= rd_d;
         o_addr_rom    <= addr_rom_d;
         o_wordcnt_rom <= wordcnt_rom_d;
      end
   end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: burst reads, arbitration order,
// address wrap, empty burst, watchdog abort and mid-burst reset.
module tb_rom_access_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  i_req;
   logic [6:0]  i_addr0, i_addr1;
   logic [7:0]  i_wordcnt0, i_wordcnt1;
   logic [1:0]  o_gnt, o_rvalid, o_done;
   logic [15:0] o_rdata;
   logic        o_err, o_rd_rom;
   logic [6:0]  o_addr_rom;
   logic [7:0]  o_wordcnt_rom;
   logic [15:0] i_data_rom_16bits;
   logic        i_fifo_full_rom;

   int n_cmp = 0;
   int n_err = 0;

   rom_access_arbiter #(.TIMEOUT(16), .TO_W(5)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_req             (i_req),
      .i_addr0           (i_addr0),
      .i_wordcnt0        (i_wordcnt0),
      .i_addr1           (i_addr1),
      .i_wordcnt1        (i_wordcnt1),
      .o_gnt             (o_gnt),
      .o_rvalid          (o_rvalid),
      .o_rdata           (o_rdata),
      .o_done            (o_done),
      .o_err             (o_err),
      .o_rd_rom          (o_rd_rom),
      .o_addr_rom        (o_addr_rom),
      .o_wordcnt_rom     (o_wordcnt_rom),
      .i_data_rom_16bits (i_data_rom_16bits),
      .i_fifo_full_rom   (i_fifo_full_rom)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      i_req = 2'b00;
      i_addr0 = '0; i_addr1 = '0;
      i_wordcnt0 = '0; i_wordcnt1 = '0;
      i_data_rom_16bits = '0;
      i_fifo_full_rom = 1'b0;

      // ---------------- reset state
      step(); step();
      chk("rst_gnt", o_gnt, 2'b00);
      chk("rst_rvalid", o_rvalid, 2'b00);
      chk("rst_done", o_done, 2'b00);
      chk("rst_err", o_err, 0);
      chk("rst_rd", o_rd_rom, 0);
      chk("rst_addr", o_addr_rom, 0);
      chk("rst_wc", o_wordcnt_rom, 0);
      chk("rst_rdata", o_rdata, 0);
      rst_n = 1'b1;
      step();

      // ---------------- req0 addr 0x10, 3 words
      i_req = 2'b01; i_addr0 = 7'h10; i_wordcnt0 = 8'd3;
      step();                                   // ISSUE
      chk("b1_gnt", o_gnt, 2'b01);
      chk("b1_rd0", o_rd_rom, 1);
      chk("b1_addr0", o_addr_rom, 7'h10);
      chk("b1_wc0", o_wordcnt_rom, 3);
      i_addr0 = 7'h55; i_wordcnt0 = 8'd9;       // must be ignored after grant
      step();                                   // WAIT
      chk("b1_wait_rd", o_rd_rom, 1);
      chk("b1_wait_addr", o_addr_rom, 7'h10);
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hA001;
      step();                                   // ISSUE word 2
      i_fifo_full_rom = 1'b0;
      chk("b1_rv1", o_rvalid, 2'b01);
      chk("b1_d1", o_rdata, 16'hA001);
      chk("b1_addr1", o_addr_rom, 7'h11);
      chk("b1_wc1", o_wordcnt_rom, 2);
      step();                                   // WAIT
      chk("b1_rv_pulse", o_rvalid, 2'b00);
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hA002;
      step();
      i_fifo_full_rom = 1'b0;
      chk("b1_rv2", o_rvalid, 2'b01);
      chk("b1_d2", o_rdata, 16'hA002);
      chk("b1_addr2", o_addr_rom, 7'h12);
      chk("b1_wc2", o_wordcnt_rom, 1);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hA003;
      step();                                   // DONE
      i_fifo_full_rom = 1'b0;
      chk("b1_rv3", o_rvalid, 2'b01);
      chk("b1_d3", o_rdata, 16'hA003);
      chk("b1_done_rd", o_rd_rom, 0);
      chk("b1_done_wc", o_wordcnt_rom, 0);
      chk("b1_done_early", o_done, 2'b00);
      chk("b1_done_gnt", o_gnt, 2'b01);
      step();                                   // IDLE, done pulse
      chk("b1_done", o_done, 2'b01);
      chk("b1_err", o_err, 0);
      chk("b1_gnt_clr", o_gnt, 2'b00);
      i_req = 2'b00;
      step();
      chk("b1_done_pulse", o_done, 2'b00);
      chk("b1_idle_gnt", o_gnt, 2'b00);

      // ---------------- simultaneous requests after reset
      do_reset();
      i_req = 2'b11;
      i_addr0 = 7'h20; i_wordcnt0 = 8'd1;
      i_addr1 = 7'h30; i_wordcnt1 = 8'd1;
      step();
      chk("rr_first_gnt", o_gnt, 2'b01);
      chk("rr_first_addr", o_addr_rom, 7'h20);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hB000;
      step();
      i_fifo_full_rom = 1'b0;
      chk("rr_first_rv", o_rvalid, 2'b01);
      step();
      chk("rr_first_done", o_done, 2'b01);
      i_req = 2'b10;
      step();
      chk("rr_second_gnt", o_gnt, 2'b10);
      chk("rr_second_addr", o_addr_rom, 7'h30);
      chk("rr_second_wc", o_wordcnt_rom, 1);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hB111;
      step();
      i_fifo_full_rom = 1'b0;
      chk("rr_second_rv", o_rvalid, 2'b10);
      chk("rr_second_d", o_rdata, 16'hB111);
      step();
      chk("rr_second_done", o_done, 2'b10);
      i_req = 2'b11;
      step();
      chk("rr_third_gnt", o_gnt, 2'b01);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hB222;
      step();
      i_fifo_full_rom = 1'b0;
      step();
      chk("rr_third_done", o_done, 2'b01);
      i_req = 2'b00;
      step();

      // ---------------- req1 address wrap 0x7F -> 0x00
      i_req = 2'b10; i_addr1 = 7'h7F; i_wordcnt1 = 8'd2;
      step();
      chk("wr_gnt", o_gnt, 2'b10);
      chk("wr_addr0", o_addr_rom, 7'h7F);
      chk("wr_wc0", o_wordcnt_rom, 2);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hC07F;
      step();
      i_fifo_full_rom = 1'b0;
      chk("wr_rv1", o_rvalid, 2'b10);
      chk("wr_d1", o_rdata, 16'hC07F);
      chk("wr_addr1", o_addr_rom, 7'h00);
      chk("wr_wc1", o_wordcnt_rom, 1);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hC000;
      step();
      i_fifo_full_rom = 1'b0;
      chk("wr_rv2", o_rvalid, 2'b10);
      chk("wr_d2", o_rdata, 16'hC000);
      step();
      chk("wr_done", o_done, 2'b10);
      i_req = 2'b00;
      step();

      // ---------------- zero-word burst, stray ROM strobe ignored
      i_req = 2'b01; i_addr0 = 7'h33; i_wordcnt0 = 8'd0;
      i_fifo_full_rom = 1'b1;
      step();                                   // DONE
      chk("z_gnt", o_gnt, 2'b01);
      chk("z_rd", o_rd_rom, 0);
      chk("z_done_early", o_done, 2'b00);
      step();                                   // two cycles after req
      i_fifo_full_rom = 1'b0;
      chk("z_done", o_done, 2'b01);
      chk("z_rv", o_rvalid, 2'b00);
      chk("z_rd2", o_rd_rom, 0);
      chk("z_err", o_err, 0);
      i_req = 2'b00;
      step();

      // ---------------- watchdog abort
      i_req = 2'b01; i_addr0 = 7'h05; i_wordcnt0 = 8'd2;
      step();                                   // ISSUE
      step();                                   // WAIT cycle 1
      for (int i = 0; i < 15; i++) step();      // WAIT cycle 16
      chk("to_still_rd", o_rd_rom, 1);
      chk("to_no_done", o_done, 2'b00);
      step();                                   // DONE
      chk("to_rd_off", o_rd_rom, 0);
      chk("to_err_early", o_err, 0);
      step();
      chk("to_done", o_done, 2'b01);
      chk("to_err", o_err, 1);
      chk("to_rv", o_rvalid, 2'b00);
      i_req = 2'b00;
      step();
      chk("to_err_pulse", o_err, 0);
      i_req = 2'b01; i_addr0 = 7'h40; i_wordcnt0 = 8'd1;
      step();
      chk("to_next_addr", o_addr_rom, 7'h40);
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hD040;
      step();
      i_fifo_full_rom = 1'b0;
      chk("to_next_rv", o_rvalid, 2'b01);
      chk("to_next_d", o_rdata, 16'hD040);
      step();
      chk("to_next_done", o_done, 2'b01);
      chk("to_next_err", o_err, 0);
      i_req = 2'b00;
      step();

      // ---------------- reset during a 5-word burst
      i_req = 2'b10; i_addr1 = 7'h08; i_wordcnt1 = 8'd5;
      step();
      step();
      i_fifo_full_rom = 1'b1; i_data_rom_16bits = 16'hE008;
      step();
      i_fifo_full_rom = 1'b0;
      chk("mr_addr1", o_addr_rom, 7'h09);
      step();                                   // WAIT
      rst_n = 1'b0;
      #1;
      chk("mr_gnt", o_gnt, 2'b00);
      chk("mr_rd", o_rd_rom, 0);
      chk("mr_addr", o_addr_rom, 0);
      chk("mr_wc", o_wordcnt_rom, 0);
      chk("mr_rdata", o_rdata, 0);
      chk("mr_rv", o_rvalid, 2'b00);
      step();
      chk("mr_no_done", o_done, 2'b00);
      rst_n = 1'b1;
      step();
      chk("mr_regnt", o_gnt, 2'b10);
      chk("mr_readdr", o_addr_rom, 7'h08);
      chk("mr_rewc", o_wordcnt_rom, 5);
      i_req = 2'b00;
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
